crc8_frame_tx_ctrl: RTL and testbench
=====================================

Name: crc8_frame_tx_ctrl

Overview:
Frame sequencer in front of crc8_encoder on the transmit side. It passes a byte stream of frames (valid/ready, last marker) through to the link and feeds each byte to the encoder. At end of frame it appends the encoder's CRC byte as the final link byte, then clears the encoder for the next frame. It replaces ad-hoc data_valid driving and gives the encoder a per-frame reset it otherwise lacks.

Parameters:
MAX_LEN, 64, maximum payload bytes per frame (excluding CRC byte); range 1..255.
FCNT_W, 16, width of completed-frame counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
s_data  in  8  payload byte from source.
s_valid  in  1  source byte valid.
s_last  in  1  byte is last of frame; qualified by s_valid.
s_ready  out  1  controller accepts byte this cycle.
m_data  out  8  link byte (payload or CRC).
m_valid  out  1  link byte valid.
m_last  out  1  link byte is the CRC byte (frame end).
m_ready  in  1  link sink accepts byte.
eng_rst  out  1  to crc8_encoder rst.
eng_data  out  8  to crc8_encoder data_in.
eng_valid  out  1  to crc8_encoder data_valid.
eng_crc  in  8  from crc8_encoder crc_out.
len_err  out  1  one-cycle pulse: frame truncated at MAX_LEN.
frame_cnt  out  FCNT_W  completed frames, wraps.
busy  out  1  state != IDLE.

Behaviour:
- Engine contract: CRC-8, poly 0x07, init 0x00, no reflection, no final XOR; one byte per eng_valid cycle; eng_crc is registered and reflects all bytes up to the previous clock edge.
- Reset (rst high, async): state=IDLE, len_cnt=0, frame_cnt=0, len_err=0, crc_q=0. eng_rst = rst OR (state==CLEAR), so it is high during reset.
- States: IDLE, DATA, WAIT_CRC, SEND_CRC, CLEAR.
- IDLE/DATA are combinational pass-through: s_ready=m_ready; m_valid=s_valid; m_data=s_data; m_last=0; eng_data=s_data; eng_valid=s_valid AND m_ready. Source bytes are never dropped or duplicated.
- On accept (s_valid AND s_ready): IDLE->DATA and len_cnt increments. If s_last=1 or len_cnt+1==MAX_LEN, go to WAIT_CRC and clear len_cnt. When the limit is hit with s_last=0, len_err pulses on the next cycle. Remaining source bytes then form a new frame.
- WAIT_CRC (1 cycle): s_ready=0, m_valid=0, eng_valid=0; crc_q<=eng_crc at end of the cycle; ->SEND_CRC.
- SEND_CRC: m_data=crc_q, m_valid=1, m_last=1, s_ready=0. Hold stable until m_ready, then ->CLEAR.
- CLEAR (1 cycle): eng_rst=1, s_ready=0, m_valid=0; frame_cnt+1 (wraps at 2^FCNT_W); ->IDLE.
- Per-frame overhead is 3 cycles, with no source acceptance during it. A frame with N bytes and m_ready stuck high uses N+3 cycles.
- m_valid, once high in SEND_CRC, does not drop before m_ready. In pass-through states it follows s_valid; the source owns stability there.
- Reset mid-frame: all state is lost, the partial frame is abandoned, and no CRC byte is emitted. The engine is cleared by eng_rst.
- A 1-byte frame (s_last on first byte) is legal. A frame of length 0 cannot occur.

Test Plan:
- Reset, then single byte 0x01 with s_last, m_ready=1 -> link sees 0x01 (m_last=0), then 0x07 with m_last=1 two cycles later; frame_cnt=1; eng_rst pulses one cycle.
- Frame 0x01,0x01 (last on second) -> link 0x01,0x01,0x12(last). Frame 0xFF next -> 0xFF,0xF3(last), proving CLEAR reset the engine; frame_cnt=2.
- ASCII "123456789" as one frame -> CRC byte 0xF4 with m_last=1.
- m_ready low 3 cycles during SEND_CRC -> m_data=0x07, m_valid=1, m_last held stable; s_ready=0 throughout; one CRC byte transferred after release.
- MAX_LEN=4, 6 bytes with s_last only on 6th -> CRC appended after byte 4 and len_err pulses once; bytes 5-6 form a second frame with its own CRC; frame_cnt=2.
- Assert rst after 2 bytes of a frame -> no CRC byte emitted, busy=0, frame_cnt=0; next frame 0xFF -> CRC 0xF3.

Source files
------------

// File: rtl/crc8_frame_tx_ctrl.sv
// Transmit-side frame sequencer in front of crc8_encoder.
// Payload bytes pass straight through to the link while being fed to the
// encoder. At end of frame (s_last, or truncation at MAX_LEN) the encoder's
// CRC byte is appended as the final link byte, then the encoder is cleared.
module crc8_frame_tx_ctrl #(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned FCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [7:0]        m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              eng_rst,
  output logic [7:0]        eng_data,
  output logic              eng_valid,
  input  logic [7:0]        eng_crc,
  output logic              len_err,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DATA     = 3'd1,
    WAIT_CRC = 3'd2,
    SEND_CRC = 3'd3,
    CLEAR    = 3'd4
  } state_t;

  // len_cnt counts bytes already accepted in the current frame; the byte
  // that would make the count reach MAX_LEN closes the frame.
  localparam logic [7:0] LAST_IDX = 8'(MAX_LEN - 1);

  state_t     state, next_state;
  logic [7:0] len_cnt;
  logic [7:0] crc_q;
  logic       at_limit;
  logic       frame_done;
  logic       truncate;

  assign at_limit = (len_cnt == LAST_IDX);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and datapath steering; pass-through in IDLE/DATA, CRC insertion otherwise.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    m_data     = s_data;
    m_last     = 1'b0;
    eng_data   = s_data;
    eng_valid  = 1'b0;
    frame_done = 1'b0;
    truncate   = 1'b0;
    case (state)
      IDLE, DATA: begin
        s_ready   = m_ready;
        m_valid   = s_valid;
        eng_valid = s_valid && m_ready;
        if (s_valid && m_ready) begin
          frame_done = s_last || at_limit;
          truncate   = at_limit && !s_last;
          next_state = frame_done ? WAIT_CRC : DATA;
        end
      end
      WAIT_CRC: next_state = SEND_CRC;
      SEND_CRC: begin
        m_data  = crc_q;
        m_valid = 1'b1;
        m_last  = 1'b1;
        if (m_ready) next_state = CLEAR;
      end
      CLEAR:    next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Frame length, truncation pulse, captured CRC and completed-frame count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_cnt   <= '0;
      len_err   <= 1'b0;
      crc_q     <= '0;
      frame_cnt <= '0;
    end else begin
      len_err <= truncate;
      if (s_valid && s_ready) begin
        len_cnt <= frame_done ? 8'd0 : len_cnt + 8'd1;
      end
      // eng_crc already includes the last payload byte by the WAIT_CRC cycle.
      if (state == WAIT_CRC) crc_q <= eng_crc;
      if (state == CLEAR)    frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Encoder is held in reset during system reset and cleared once per frame.
  assign eng_rst = rst || (state == CLEAR);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_crc8_frame_tx_ctrl.sv
// Self-checking bench for crc8_frame_tx_ctrl with a behavioural CRC-8 engine
// attached to the eng_* ports and a frame-level model of the link stream.
module tb_crc8_frame_tx_ctrl;

  localparam int MAX_LEN = 9;
  localparam int FCNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [7:0]        m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;
  logic              eng_rst;
  logic [7:0]        eng_data;
  logic              eng_valid;
  logic [7:0]        eng_crc;
  logic              len_err;
  logic [FCNT_W-1:0] frame_cnt;
  logic              busy;

  crc8_frame_tx_ctrl #(.MAX_LEN(MAX_LEN), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .eng_rst(eng_rst), .eng_data(eng_data), .eng_valid(eng_valid), .eng_crc(eng_crc),
    .len_err(len_err), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC-8 poly 0x07, init 0, MSB first, one byte.
  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // Behavioural crc8_encoder: registered CRC, cleared by eng_rst.
  logic [7:0] eng_crc_r;
  always @(posedge clk or posedge eng_rst) begin
    if (eng_rst)        eng_crc_r <= 8'h00;
    else if (eng_valid) eng_crc_r <= crc_upd(eng_crc_r, eng_data);
  end
  assign eng_crc = eng_crc_r;

  // Frame-level model: expected link stream {last, data}.
  logic [8:0] exp_q[$];
  logic [7:0] m_bytes[$];
  int         exp_fcnt = 0;
  int         exp_lerr = 0;

  task automatic model_byte(input logic [7:0] b, input logic last);
    logic [7:0] c;
    exp_q.push_back({1'b0, b});
    m_bytes.push_back(b);
    if (last || m_bytes.size() == MAX_LEN) begin
      c = 8'h00;
      foreach (m_bytes[i]) c = crc_upd(c, m_bytes[i]);
      exp_q.push_back({1'b1, c});
      if (!last) exp_lerr++;
      m_bytes.delete();
      exp_fcnt++;
    end
  endtask

  // Observation counters fed by the compare process.
  int         cyc = 0;
  int         data_cyc = 0;
  int         crc_cyc = 0;
  int         lerr_seen = 0;
  int         eng_rst_seen = 0;
  logic [7:0] last_crc = 8'h00;

  always @(posedge clk) cyc++;

  // Compare process: every link transfer against the model, plus per-cycle invariants.
  always @(negedge clk) begin
    if (!rst) begin
      if (len_err) lerr_seen++;
      if (eng_rst) eng_rst_seen++;
      if (m_last) check("s_ready_low_in_crc", 32'(s_ready), 32'd0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_link_byte: got last=%0b data=0x%0h expected none", m_last, m_data);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("link_byte", 32'({m_last, m_data}), 32'(e));
          if (m_last) begin
            last_crc = m_data;
            crc_cyc  = cyc;
          end else begin
            data_cyc = cyc;
          end
        end
      end
    end
  end

  // Drivers: called and returning at posedge+1.
  task automatic put_byte(input logic [7:0] b, input logic last);
    int n;
    s_data  = b;
    s_last  = last;
    s_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready || n >= 100) break;
      n++;
    end
    if (n >= 100) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    model_byte(b, last);
    put_byte(b, last);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_in_time"}, 32'(n < 100), 32'd1);
    check({name, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_fcnt));
    check({name, "_len_err_pulses"}, 32'(lerr_seen), 32'(exp_lerr));
    @(posedge clk);
    #1;
  endtask

  initial begin
    string s;
    rst     = 1'b1;
    s_data  = 8'h00;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_eng_rst", 32'(eng_rst), 32'd1);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single byte frame; CRC two cycles after the payload byte.
    send_byte(8'h01, 1'b1);
    wait_idle("t1");
    check("t1_crc_literal", 32'(last_crc), 32'h07);
    check("t1_crc_gap", 32'(crc_cyc - data_cyc), 32'd2);
    check("t1_eng_rst_pulses", 32'(eng_rst_seen), 32'd1);

    // Two-byte frame, then a frame proving the engine was cleared.
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b1);
    wait_idle("t2a");
    check("t2a_crc_literal", 32'(last_crc), 32'h12);
    send_byte(8'hFF, 1'b1);
    wait_idle("t2b");
    check("t2b_crc_literal", 32'(last_crc), 32'hF3);

    // Check string, exactly MAX_LEN bytes with s_last: no truncation.
    s = "123456789";
    for (int i = 0; i < 9; i++) send_byte(s[i], i == 8);
    wait_idle("t3");
    check("t3_crc_literal", 32'(last_crc), 32'hF4);
    check("t3_no_len_err", 32'(lerr_seen), 32'd0);

    // CRC byte held under back-pressure.
    send_byte(8'h01, 1'b1);
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(m_valid), 32'd1);
      check("t4_hold_data", 32'(m_data), 32'h07);
      check("t4_hold_last", 32'(m_last), 32'd1);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    wait_idle("t4");
    check("t4_crc_literal", 32'(last_crc), 32'h07);

    // Truncation: 11 bytes, s_last only on the 11th.
    for (int i = 0; i < 11; i++) send_byte(8'(8'h10 + i), i == 10);
    wait_idle("t5");
    check("t5_one_len_err", 32'(lerr_seen), 32'd1);

    // Reset mid-frame: partial frame abandoned, no CRC byte.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    rst = 1'b1;
    m_bytes.delete();
    exp_fcnt = 0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("t6_rst_eng_rst", 32'(eng_rst), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_byte(8'hFF, 1'b1);
    wait_idle("t6");
    check("t6_crc_literal", 32'(last_crc), 32'hF3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
